// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package imem_port_arbiter_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int MEM_WORD_BYTES = 4;
  localparam int WORD_OFS = $clog2(MEM_WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    F_RD1 = 2'd1,
    F_RD2 = 2'd2,
    D_RD  = 2'd3
  } arb_state_e;

  // A halfword whose two low bits are not 2'b11 starts a compressed instruction.
  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/imem_port_arbiter_starve_ctr.sv
// Fixed-priority select (data first) with a saturating counter that lets a
// waiting fetch in after MaxDataBurst back-to-back data grants.
module arb_starve_ctr #(
  parameter int MaxDataBurst = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic f_req,
  input  logic f_flush,
  input  logic d_req,
  output logic f_gnt,
  output logic d_gnt
);

  localparam int CW = $clog2(MaxDataBurst + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MaxDataBurst);

  logic [CW-1:0] cnt;
  logic          f_eligible;
  logic          f_wins;

  // Data has priority unless the fetch side has been starved long enough.
  always_comb begin
    f_eligible = f_req & ~f_flush;
    f_wins     = f_eligible & (cnt == CNT_MAX);
    d_gnt      = idle & d_req & ~f_wins;
    f_gnt      = idle & f_eligible & ~d_gnt;
  end

  // Count data grants that overtake a pending fetch; any fetch grant or idle fetch side clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (f_gnt || !f_req) begin
      cnt <= '0;
    end else if (d_gnt && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one synchronous-read word memory between instruction fetch and the
// LSU; reassembles 32-bit instructions that straddle a word boundary.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int AW           = 12,
  parameter int MaxDataBurst = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            f_req_i,
  input  logic [XLEN-1:0] f_addr_i,
  input  logic            f_flush_i,
  output logic            f_gnt_o,
  output logic            f_rvalid_o,
  output logic [31:0]     f_rdata_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [3:0]      d_be_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [31:0]     d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [31:0]     d_rdata_o,
  output logic            mem_en_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [31:0]     mem_wdata_o,
  input  logic [31:0]     mem_rdata_i
);

  arb_state_e    state;
  logic          hi_sel;
  logic [AW-1:0] word_q;
  logic [15:0]   saved_q;
  logic          idle;
  logic          need_second;
  logic          unused_bits;

  assign unused_bits = ^{f_addr_i[XLEN-1:AW+WORD_OFS], f_addr_i[0],
                         d_addr_i[XLEN-1:AW+WORD_OFS], d_addr_i[WORD_OFS-1:0]};

  assign idle = (state == IDLE) & ~rst_i;

  arb_starve_ctr #(
    .MaxDataBurst(MaxDataBurst)
  ) u_starve (
    .clk    (clk_i),
    .rst    (rst_i),
    .idle   (idle),
    .f_req  (f_req_i),
    .f_flush(f_flush_i),
    .d_req  (d_req_i),
    .f_gnt  (f_gnt_o),
    .d_gnt  (d_gnt_o)
  );

  // A misaligned fetch whose upper halfword starts a 32-bit instruction needs the next word.
  assign need_second = (state == F_RD1) & ~f_flush_i & hi_sel &
                       ~is_compressed(mem_rdata_i[31:16]);

  // Memory strobes and response outputs; everything held at zero while in reset.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    f_rvalid_o  = 1'b0;
    f_rdata_o   = 32'h0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = 32'h0;
    if (!rst_i) begin
      case (state)
        IDLE: begin
          if (f_gnt_o) begin
            mem_en_o   = 1'b1;
            mem_addr_o = f_addr_i[AW+WORD_OFS-1:WORD_OFS];
          end else if (d_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = d_we_i;
            mem_be_o    = d_be_i;
            mem_addr_o  = d_addr_i[AW+WORD_OFS-1:WORD_OFS];
            mem_wdata_o = d_we_i ? d_wdata_i : 32'h0;
          end
        end
        F_RD1: begin
          if (need_second) begin
            mem_en_o   = 1'b1;
            mem_addr_o = word_q + AW'(1);
          end else if (!f_flush_i) begin
            f_rvalid_o = 1'b1;
            f_rdata_o  = hi_sel ? {16'h0, mem_rdata_i[31:16]} : mem_rdata_i;
          end
        end
        F_RD2: begin
          if (!f_flush_i) begin
            f_rvalid_o = 1'b1;
            f_rdata_o  = {mem_rdata_i[15:0], saved_q};
          end
        end
        D_RD: begin
          d_rvalid_o = 1'b1;
          d_rdata_o  = mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

  // Sequencing state and the fetch context carried between memory reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      hi_sel  <= 1'b0;
      word_q  <= '0;
      saved_q <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (f_gnt_o) begin
            state  <= F_RD1;
            hi_sel <= f_addr_i[1];
            word_q <= f_addr_i[AW+WORD_OFS-1:WORD_OFS];
          end else if (d_gnt_o && !d_we_i) begin
            state <= D_RD;
          end
        end
        F_RD1: begin
          if (need_second) begin
            saved_q <= mem_rdata_i[31:16];
            state   <= F_RD2;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized and directed checks of imem_port_arbiter against a word-level
// reference memory and the fetch reassembly rules.
module tb_imem_port_arbiter;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = 32'h0;
  logic        f_flush = 1'b0;
  logic        f_gnt, f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = 4'h0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.AW(AW), .MaxDataBurst(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_flush_i(f_flush),
    .f_gnt_o(f_gnt), .f_rvalid_o(f_rvalid), .f_rdata_o(f_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
    .d_rdata_o(d_rdata), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  // Memory macro: synchronous read, byte-enabled write.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  function automatic logic [31:0] exp_fetch(input logic [31:0] a);
    int w, wn;
    logic [15:0] hi;
    w  = int'(a[13:2]);
    wn = (w + 1) % DEPTH;
    hi = ref_mem[w][31:16];
    if (!a[1]) return ref_mem[w];
    if (hi[1:0] != 2'b11) return {16'h0, hi};
    return {ref_mem[wn][15:0], hi};
  endfunction

  function automatic bit is_long(input logic [31:0] a);
    logic [15:0] hi;
    hi = ref_mem[int'(a[13:2])][31:16];
    return a[1] && (hi[1:0] == 2'b11);
  endfunction

  task automatic do_fetch(input logic [31:0] a, input bit flush);
    logic [31:0] e;
    logic [AW-1:0] nw;
    @(negedge clk);
    f_flush = 1'b0; f_req = 1'b1; f_addr = a; #1;
    chk("f_gnt", {31'h0, f_gnt}, 32'h1);
    chk("f_no_dgnt", {31'h0, d_gnt}, 32'h0);
    chk("f_mem_en", {31'h0, mem_en}, 32'h1);
    chk("f_mem_addr", {20'h0, mem_addr}, {20'h0, a[13:2]});
    chk("f_mem_we", {31'h0, mem_we}, 32'h0);
    chk("f_mem_be", {28'h0, mem_be}, 32'h0);
    e  = exp_fetch(a);
    nw = a[13:2] + 12'd1;
    @(negedge clk);
    f_req = 1'b0; f_addr = $urandom; f_flush = flush; #1;
    if (flush) begin
      chk("fl_rvalid", {31'h0, f_rvalid}, 32'h0);
      chk("fl_mem_en", {31'h0, mem_en}, 32'h0);
    end else if (!is_long(a)) begin
      chk("f1_rvalid", {31'h0, f_rvalid}, 32'h1);
      chk("f1_rdata", f_rdata, e);
      chk("f1_mem_en", {31'h0, mem_en}, 32'h0);
    end else begin
      chk("f2a_rvalid", {31'h0, f_rvalid}, 32'h0);
      chk("f2a_mem_en", {31'h0, mem_en}, 32'h1);
      chk("f2a_mem_addr", {20'h0, mem_addr}, {20'h0, nw});
      chk("f2a_mem_we", {31'h0, mem_we}, 32'h0);
      @(negedge clk); #1;
      chk("f2b_rvalid", {31'h0, f_rvalid}, 32'h1);
      chk("f2b_rdata", f_rdata, e);
    end
  endtask

  task automatic do_data(input bit we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
    int w;
    w = int'(a[13:2]);
    @(negedge clk);
    f_flush = 1'b0; d_req = 1'b1; d_we = we; d_addr = a; d_be = be; d_wdata = wd; #1;
    chk("d_gnt", {31'h0, d_gnt}, 32'h1);
    chk("d_no_fgnt", {31'h0, f_gnt}, 32'h0);
    chk("d_mem_en", {31'h0, mem_en}, 32'h1);
    chk("d_mem_we", {31'h0, mem_we}, {31'h0, we});
    chk("d_mem_addr", {20'h0, mem_addr}, {20'h0, a[13:2]});
    if (we) begin
      chk("d_mem_be", {28'h0, mem_be}, {28'h0, be});
      chk("d_mem_wdata", mem_wdata, wd);
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
    end
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0; #1;
    chk("d_rvalid", {31'h0, d_rvalid}, {31'h0, !we});
    if (!we) chk("d_rdata", d_rdata, ref_mem[w]);
  endtask

  // Holds a data read request every cycle and a fetch request per fmask bit;
  // reports the first two fetch grant cycles and data grants preceding each.
  task automatic run_contention(input logic [31:0] fmask, input int ncyc,
                                output int f1, output int f2, output int nd1, output int nd2);
    f1 = -1; f2 = -1; nd1 = 0; nd2 = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      f_flush = 1'b0; f_req = fmask[c]; f_addr = 32'h4;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; #1;
      if (f_gnt) begin
        if (f1 < 0) f1 = c;
        else if (f2 < 0) f2 = c;
      end
      if (d_gnt) begin
        if (f1 < 0) nd1++;
        else if (f2 < 0) nd2++;
      end
    end
    @(negedge clk);
    f_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int f1, f2, nd1, nd2;
    logic [31:0] fm;
    for (int i = 0; i < DEPTH; i++) set_word(i, $urandom);

    // Requests asserted throughout reset must see all-zero outputs.
    f_req = 1'b1; d_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_f_gnt", {31'h0, f_gnt}, 32'h0);
    chk("rst_d_gnt", {31'h0, d_gnt}, 32'h0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_rvalids", {30'h0, f_rvalid, d_rvalid}, 32'h0);
    f_req = 1'b0; d_req = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Directed cases.
    set_word(0, 32'h0050_0093);
    do_fetch(32'h0, 1'b0);
    set_word(0, 32'h4505_1234);
    do_fetch(32'h2, 1'b0);
    set_word(0, 32'h0093_1234);
    set_word(1, 32'hABCD_0050);
    do_fetch(32'h2, 1'b0);
    set_word(DEPTH-1, 32'h0093_5555);
    set_word(0, 32'h7777_0050);
    do_fetch({18'h0, 12'hFFF, 2'b10}, 1'b0);
    set_word(0, 32'h0093_1234);
    do_fetch(32'h2, 1'b1);
    do_data(1'b0, 32'h10, 4'hF, 32'h0);
    set_word(0, 32'h0);
    do_data(1'b1, 32'h0, 4'b0011, 32'hDEAD_BEEF);
    do_data(1'b0, 32'h0, 4'hF, 32'h0);

    // A flushed fetch request is never granted.
    @(negedge clk);
    f_req = 1'b1; f_flush = 1'b1; f_addr = 32'h0; #1;
    chk("flush_no_gnt", {31'h0, f_gnt}, 32'h0);
    chk("flush_no_en", {31'h0, mem_en}, 32'h0);
    @(negedge clk);
    f_req = 1'b0; f_flush = 1'b0;

    // Starvation: both held, then with a one-cycle gap in the fetch request.
    fm = 32'hFFFF_FFFF;
    run_contention(fm, 20, f1, f2, nd1, nd2);
    chk("starve_f1", f1, 8);
    chk("starve_nd1", nd1, 4);
    chk("starve_f2", f2, 18);
    chk("starve_nd2", nd2, 4);
    fm = 32'hFFFF_FFDF;
    run_contention(fm, 16, f1, f2, nd1, nd2);
    chk("gap_f1", f1, 14);
    chk("gap_nd1", nd1, 7);

    // Reset in the middle of a data read drops the response.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; #1;
    chk("mid_d_gnt", {31'h0, d_gnt}, 32'h1);
    @(negedge clk);
    d_req = 1'b0; rst = 1'b1; #1;
    chk("mid_rst_rvalid", {31'h0, d_rvalid}, 32'h0);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("post_rst_rvalid", {31'h0, d_rvalid}, 32'h0);
    chk("post_rst_en", {31'h0, mem_en}, 32'h0);

    // Randomized mix of fetches, flushes, writes and reads.
    for (int n = 0; n < 120; n++) begin
      int kind;
      logic [11:0] w;
      logic [31:0] a;
      kind = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) w = 12'hFFF - 12'($urandom_range(0, 1));
      else w = 12'($urandom_range(0, 31));
      a = {18'h0, w, 2'b00};
      case (kind)
        0: begin a[1] = $urandom_range(0, 1) == 1; do_fetch(a, 1'b0); end
        1: begin a[1] = $urandom_range(0, 1) == 1; do_fetch(a, 1'b1); end
        2: do_data(1'b1, a, 4'($urandom_range(0, 15)), $urandom);
        default: do_data(1'b0, a, 4'hF, 32'h0);
      endcase
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
